// File: rtl/gf163_pkg.sv
// Shared constants and types for the GF(2^163) Itoh-Tsujii inverter.
package gf163_pkg;

  // Field degree and the low terms of f(x) = x^163 + x^7 + x^6 + x^3 + 1.
  localparam int              GF_M    = 163;
  localparam logic [GF_M-1:0] GF_POLY = 163'hC9;

  // Every nonzero term of GF_POLY lies below x^8.
  localparam int GF_TAPW = 8;

  // Addition chain 1,2,4,5,10,20,40,80,81,162 expressed as nine
  // square-then-multiply steps. SQ_CNT is the number of squarings before
  // each multiply. B_SEL picks the second multiplier operand: 0 multiplies
  // by the beta saved at the start of the step, 1 multiplies by the input.
  localparam int         N_STEPS   = 9;
  localparam logic [3:0] LAST_STEP = 4'd8;

  localparam logic [6:0] SQ_CNT [N_STEPS] = '{
    7'd1, 7'd2, 7'd1, 7'd5, 7'd10, 7'd20, 7'd40, 7'd1, 7'd81
  };

  localparam logic B_SAVED = 1'b0;
  localparam logic B_AREG  = 1'b1;

  localparam logic B_SEL [N_STEPS] = '{
    B_SAVED, B_SAVED, B_AREG, B_SAVED, B_SAVED, B_SAVED, B_SAVED, B_AREG, B_SAVED
  };

  // Inverter control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SQR   = 3'd2,
    ST_MREQ  = 3'd3,
    ST_FSQ   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/gf163_inverter_if.sv
// Request/result bus of the inverter plus its link to the shared multiplier.
interface gf163_inverter_if;
  import gf163_pkg::*;

  // Client side
  logic            start;
  logic [GF_M-1:0] a_in;
  logic            busy;
  logic            done;
  logic            zero_err;
  logic [GF_M-1:0] z;

  // Multiplier side
  logic            mul_start;
  logic [GF_M-1:0] mul_a;
  logic [GF_M-1:0] mul_b;
  logic [GF_M-1:0] mul_z;
  logic            mul_done;

  // Environment: client plus multiplier.
  modport master (
    output start, a_in, mul_z, mul_done,
    input  busy, done, zero_err, z, mul_start, mul_a, mul_b
  );

  // The inverter itself.
  modport slave (
    input  start, a_in, mul_z, mul_done,
    output busy, done, zero_err, z, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/gf163_square.sv
// Combinational squaring in GF(2^163): spread the bits, then fold the upper
// half back with f(x). Two folds are enough: the first leaves at most six
// bits above x^162, the second lands well below it.
module gf163_square
  import gf163_pkg::*;
(
  input  logic [GF_M-1:0] i_a,
  output logic [GF_M-1:0] o_sq
);

  localparam int SW  = 2*GF_M - 1;          // spread width, 325
  localparam int F1W = GF_M + GF_TAPW - 1;  // width after the first fold

  logic [SW-1:0]   w_s;
  logic [F1W-1:0]  w_h1;
  logic [F1W-1:0]  w_f1;
  logic [GF_M-1:0] w_h2;

  // Squaring in characteristic 2 only interleaves zeros: s[2i] = a[i].
  for (genvar gi = 0; gi < GF_M; gi++) begin : g_spread
    assign w_s[2*gi] = i_a[gi];
    if (gi < GF_M-1) begin : g_odd
      assign w_s[2*gi+1] = 1'b0;
    end
  end

  // Fold x^(163+j) into x^j * (x^7 + x^6 + x^3 + 1), twice.
  always_comb begin
    w_h1 = F1W'(w_s[SW-1:GF_M]);
    w_f1 = F1W'(w_s[GF_M-1:0]);
    for (int k = 0; k < GF_TAPW; k++) begin
      if (GF_POLY[k]) w_f1 = w_f1 ^ (w_h1 << k);
    end
    w_h2 = GF_M'(w_f1[F1W-1:GF_M]);
    o_sq = w_f1[GF_M-1:0];
    for (int k = 0; k < GF_TAPW; k++) begin
      if (GF_POLY[k]) o_sq = o_sq ^ (w_h2 << k);
    end
  end

endmodule

// File: rtl/gf163_inverter.sv
// Itoh-Tsujii inverter for GF(2^163): a^-1 = a^(2^163 - 2).
// Squarings run internally at one per cycle; the nine multiplications are
// handed to the shared multiplier over a start/done handshake.
module gf163_inverter
  import gf163_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  gf163_inverter_if.slave  io_bus
);

  state_t          r_state;
  state_t          w_next;

  logic [GF_M-1:0] r_t;      // running power of a
  logic [GF_M-1:0] r_saved;  // beta captured at the start of each step
  logic [GF_M-1:0] r_a;      // input operand
  logic [GF_M-1:0] r_z;      // last result, held between operations
  logic [6:0]      r_cnt;    // squarings left in this step
  logic [3:0]      r_step;   // addition-chain step, 0..8
  logic            r_zero;   // operand of the current run was zero

  logic [GF_M-1:0] w_sq;
  logic [GF_M-1:0] w_res;
  logic            w_a_zero;

  // One squarer serves both the chain squarings and the final square.
  gf163_square u_square (
    .i_a  (r_t),
    .o_sq (w_sq)
  );

  assign w_a_zero = (io_bus.a_in == '0);
  assign w_res    = r_zero ? '0 : r_t;

  // State register; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: walk the nine square-multiply steps, then one square.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) w_next = w_a_zero ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: w_next = ST_SQR;
      ST_SQR: begin
        if (r_cnt == 7'd1) w_next = ST_MREQ;
      end
      ST_MREQ: begin
        if (io_bus.mul_done) w_next = (r_step == LAST_STEP) ? ST_FSQ : ST_SETUP;
      end
      ST_FSQ:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath registers, each updated only in the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t     <= '0;
      r_saved <= '0;
      r_a     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_step  <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start) begin
            r_a    <= io_bus.a_in;
            r_t    <= io_bus.a_in;
            r_step <= '0;
            r_zero <= w_a_zero;
          end
        end
        ST_SETUP: begin
          r_saved <= r_t;
          r_cnt   <= SQ_CNT[r_step];
        end
        ST_SQR: begin
          r_t   <= w_sq;
          r_cnt <= r_cnt - 7'd1;
        end
        ST_MREQ: begin
          // Product is taken only here; a stray mul_done elsewhere is ignored.
          if (io_bus.mul_done) begin
            r_t <= io_bus.mul_z;
            if (r_step != LAST_STEP) r_step <= r_step + 4'd1;
          end
        end
        ST_FSQ:  r_t <= w_sq;
        ST_DONE: r_z <= w_res;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so that reset clears them at once.
  // z shows the fresh result during the done cycle and r_z afterwards.
  assign io_bus.busy      = (r_state != ST_IDLE);
  assign io_bus.done      = (r_state == ST_DONE);
  assign io_bus.zero_err  = (r_state == ST_DONE) && r_zero;
  assign io_bus.z         = (r_state == ST_DONE) ? w_res : r_z;
  assign io_bus.mul_start = (r_state == ST_MREQ);
  assign io_bus.mul_a     = r_t;
  assign io_bus.mul_b     = (B_SEL[r_step] == B_AREG) ? r_a : r_saved;

endmodule

// File: tb/tb_gf163_inverter.sv
// Bench for gf163_inverter: directed vector table, a few random operands,
// and hand-written sequences for stray inputs and reset during a multiply.
module tb_gf163_inverter;

  localparam int              M    = 163;
  localparam logic [M-1:0]    POLY = 163'hC9;
  localparam int              BASE = 171;  // fixed part of the latency

  logic clk = 1'b0;
  logic rst;

  gf163_inverter_if bus ();

  gf163_inverter dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int g_d   = 1;   // multiplier delay; 0 selects random 1..200 per request
  int acc_d = 0;   // running sum of (D+1) over served requests
  int n_rise = 0;
  logic prev_ms = 1'b0;
  logic mdl_done = 1'b0;
  logic inj_done = 1'b0;
  logic [M-1:0] mdl_z = '0;

  assign bus.mul_done = mdl_done | inj_done;
  assign bus.mul_z    = mdl_z;

  // Reference shift-and-add multiply modulo f.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = M-1; i >= 0; i--) begin
      r = r[M-1] ? ((r << 1) ^ POLY) : (r << 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_a();
    logic [191:0] w;
    logic [M-1:0] r;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = w[M-1:0];
    if (r == '0) r = 163'd1;
    return r;
  endfunction

  task automatic chk_v(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Rising edges of mul_start.
  initial forever begin
    @(negedge clk);
    if (bus.mul_start === 1'b1 && prev_ms !== 1'b1) n_rise++;
    prev_ms = bus.mul_start;
  end

  // Behavioural multiplier: mul_done arrives D cycles after mul_start rises.
  initial begin
    int d;
    logic [M-1:0] p;
    forever begin
      @(posedge clk); #1;
      if (bus.mul_start === 1'b1) begin
        d = (g_d == 0) ? int'($urandom_range(200, 1)) : g_d;
        p = gf_mul(bus.mul_a, bus.mul_b);
        repeat (d) @(posedge clk);
        #1;
        mdl_z    = p;
        mdl_done = 1'b1;
        @(posedge clk); #1;
        mdl_done = 1'b0;
        acc_d += d + 1;
      end
    end
  end

  // Start one inversion and wait (bounded) for done.
  // lat counts edges from the start edge to the edge that enters DONE.
  task automatic run_op(input logic [M-1:0] a, input int d,
                        output logic [M-1:0] z, output logic zerr,
                        output int lat, output int nreq, output int dsum, output bit ok);
    int c0, r0, s0;
    g_d = d;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    @(posedge clk); #1;
    c0 = cyc; r0 = n_rise; s0 = acc_d;
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    lat  = cyc - c0;
    z    = bus.z;
    zerr = bus.zero_err;
    nreq = n_rise - r0;
    dsum = acc_d - s0;
  endtask

  typedef struct {
    logic [M-1:0] a;
    int           d;
    logic [M-1:0] z;
    logic         zerr;
    int           lat;
    int           nreq;
  } vec_t;

  initial begin
    vec_t tv [5];
    int dm [5];
    logic [M-1:0] inv_x, a, za;
    logic ze;
    int lat, nreq, dsum, c0, s0, falls;
    bit ok;
    logic prev;

    bus.start = 1'b0;
    bus.a_in  = '0;
    rst = 1'b1;

    // x^-1 = x^162 + x^6 + x^5 + x^2, since x * that = x^163 + x^7 + x^6 + x^3 = 1.
    inv_x = '0;
    inv_x[162] = 1'b1; inv_x[6] = 1'b1; inv_x[5] = 1'b1; inv_x[2] = 1'b1;

    // {a, D, z, zero_err, latency, multiplier requests}
    tv[0] = '{163'd1, 1,   163'd1, 1'b0, BASE + 9*2,   9};
    tv[1] = '{163'd2, 163, inv_x,  1'b0, BASE + 9*164, 9};
    tv[2] = '{inv_x,  5,   163'd2, 1'b0, BASE + 9*6,   9};
    tv[3] = '{163'd0, 7,   163'd0, 1'b1, 0,            0};  // done in the first cycle
    tv[4] = '{163'd1, 2,   163'd1, 1'b0, BASE + 9*3,   9};
    dm = '{1, 163, 0, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_busy", bus.busy, 1'b0);
    chk_b("rst_done", bus.done, 1'b0);
    chk_b("rst_zero_err", bus.zero_err, 1'b0);
    chk_v("rst_z", bus.z, '0);
    chk_b("rst_mul_start", bus.mul_start, 1'b0);
    chk_v("rst_mul_a", bus.mul_a, '0);
    chk_v("rst_mul_b", bus.mul_b, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i].a, tv[i].d, za, ze, lat, nreq, dsum, ok);
      chk_b($sformatf("tbl%0d_done_seen", i), ok, 1'b1);
      chk_v($sformatf("tbl%0d_z", i), za, tv[i].z);
      chk_b($sformatf("tbl%0d_zero_err", i), ze, tv[i].zerr);
      chk_i($sformatf("tbl%0d_latency", i), lat, tv[i].lat);
      chk_i($sformatf("tbl%0d_mul_reqs", i), nreq, tv[i].nreq);
      @(posedge clk); #1;
      chk_b($sformatf("tbl%0d_done_pulse", i), bus.done, 1'b0);
      chk_v($sformatf("tbl%0d_z_hold", i), bus.z, tv[i].z);
    end

    // Random nonzero operands
    for (int i = 0; i < 5; i++) begin
      a = rand_a();
      run_op(a, dm[i], za, ze, lat, nreq, dsum, ok);
      chk_b($sformatf("rnd%0d_done_seen", i), ok, 1'b1);
      chk_v($sformatf("rnd%0d_inverse", i), gf_mul(za, a), 163'd1);
      chk_b($sformatf("rnd%0d_zero_err", i), ze, 1'b0);
      chk_i($sformatf("rnd%0d_mul_reqs", i), nreq, 9);
      chk_i($sformatf("rnd%0d_latency", i), lat, BASE + dsum);
    end

    // start while busy and mul_done during squaring are both ignored
    a = rand_a();
    g_d = 3;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    @(posedge clk); #1;
    c0 = cyc;
    s0 = acc_d;
    bus.start = 1'b0;
    chk_b("seq_busy", bus.busy, 1'b1);
    falls = 0;
    prev  = 1'b0;
    for (int i = 0; i < 3000 && falls < 4; i++) begin
      @(posedge clk); #1;
      if (prev === 1'b1 && bus.mul_start === 1'b0) falls++;
      prev = bus.mul_start;
    end
    chk_i("seq_reach_step4", falls, 4);
    @(posedge clk); #1;                 // now squaring in step 4 (10 cycles)
    inj_done  = 1'b1;
    bus.start = 1'b1;
    bus.a_in  = ~a;
    chk_b("seq_in_sqr", bus.mul_start, 1'b0);
    @(posedge clk); #1;
    inj_done  = 1'b0;
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk_b("seq_done_seen", ok, 1'b1);
    chk_v("seq_inverse", gf_mul(bus.z, a), 163'd1);
    chk_i("seq_latency", cyc - c0, BASE + 9*4);
    chk_i("seq_latency_model", acc_d - s0, 9*4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_b("seq_no_queued_start", bus.busy, 1'b0);

    // Reset while a multiply is outstanding
    a = rand_a();
    g_d = 50;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 500 && bus.mul_start !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk_b("abort_in_mreq", bus.mul_start, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_b("abort_busy", bus.busy, 1'b0);
    chk_b("abort_done", bus.done, 1'b0);
    chk_b("abort_zero_err", bus.zero_err, 1'b0);
    chk_v("abort_z", bus.z, '0);
    chk_b("abort_mul_start", bus.mul_start, 1'b0);
    chk_v("abort_mul_a", bus.mul_a, '0);
    chk_v("abort_mul_b", bus.mul_b, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    a = rand_a();
    run_op(a, 4, za, ze, lat, nreq, dsum, ok);
    chk_b("post_done_seen", ok, 1'b1);
    chk_v("post_inverse", gf_mul(za, a), 163'd1);
    chk_b("post_zero_err", ze, 1'b0);
    chk_i("post_mul_reqs", nreq, 9);
    chk_i("post_latency", lat, BASE + 9*5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
